// File: rtl/four_bit_divider.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock, ena/done handshake.
// Optional macro DIVIDER_DBZ_CHECK_EN short-circuits B==0 to a flagged all-ones result.
module four_bit_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [DVD_W-1:0] A,
  input  logic [DVS_W-1:0] B,
  output logic [DVD_W-1:0] Q,
  output logic [DVS_W-1:0] R,
  output logic             done,
  output logic             busy,
  output logic             dbz,
  output logic [2:0]       state
);

  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DVD_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_END  = 3'd3
  } state_t;

  state_t cur, nxt;

  logic [DVD_W-1:0] a_reg;
  logic [DVS_W-1:0] b_reg;
  logic [DVS_W:0]   p_reg;
  logic [DVD_W-1:0] s_reg;
  logic [CNT_W-1:0] cnt;
  logic [DVS_W+1:0] step;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // subtract the divisor if it fits. Returns {next partial remainder, quotient bit}.
  function automatic logic [DVS_W+1:0] div_step(input logic [DVS_W:0]   p,
                                                input logic             s_msb,
                                                input logic [DVS_W-1:0] b);
    logic [DVS_W:0] t;
    t = (DVS_W+1)'({p, s_msb});
    if (t >= {1'b0, b})
      div_step = {t - {1'b0, b}, 1'b1};
    else
      div_step = {t, 1'b0};
  endfunction

  assign step  = div_step(p_reg, s_reg[DVD_W-1], b_reg);
  assign state = cur;

  always_ff @(posedge clk) begin
    if (!rst)
      cur <= ST_IDLE;
    else
      cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE: if (ena) nxt = ST_LOAD;
      ST_LOAD: begin
`ifdef DIVIDER_DBZ_CHECK_EN
        if (b_reg == '0)
          nxt = ST_END;
        else
          nxt = ST_ITER;
`else
        nxt = ST_ITER;
`endif
      end
      // The counter is sampled before its decrement, so codes DVD_W-1..0 give DVD_W iterations.
      ST_ITER: if (cnt == '0) nxt = ST_END;
      ST_END:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    case (cur)
      ST_LOAD, ST_ITER, ST_END: busy = 1'b1;
      default:                  busy = 1'b0;
    endcase
  end

`ifdef DIVIDER_DBZ_CHECK_EN
  logic dbz_pend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dbz_pend <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      case (cur)
        ST_IDLE: if (ena) dbz <= 1'b0;
        ST_LOAD: dbz_pend <= (b_reg == '0);
        ST_END:  dbz <= dbz_pend;
        default: ;
      endcase
    end
  end
`else
  assign dbz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
      s_reg <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      done  <= 1'b0;
    end else begin
      done <= (cur == ST_END);
      case (cur)
        ST_IDLE: begin
          if (ena) begin
            a_reg <= A;
            b_reg <= B;
          end
        end
        ST_LOAD: begin
          p_reg <= '0;
          s_reg <= a_reg;
          cnt   <= CNT_INIT;
        end
        ST_ITER: begin
          p_reg <= step[DVS_W+1:1];
          s_reg <= {s_reg[DVD_W-2:0], step[0]};
          cnt   <= cnt - 1'b1;
        end
        ST_END: begin
`ifdef DIVIDER_DBZ_CHECK_EN
          if (dbz_pend) begin
            Q <= '1;
            R <= '0;
          end else begin
            Q <= s_reg;
            R <= p_reg[DVS_W-1:0];
          end
`else
          Q <= s_reg;
          R <= p_reg[DVS_W-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_divider.sv
// Directed bench for four_bit_divider: reset, latency, directed pairs, full sweep, B==0, overlap and abort.
module tb_four_bit_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] A = '0;
  logic [3:0] B = '0;
  logic [7:0] Q;
  logic [3:0] R;
  logic       done, busy, dbz;
  logic [2:0] state;

  int n_vec = 0;
  int n_bad = 0;

  four_bit_divider dut (
    .clk(clk), .rst(rst), .ena(ena), .A(A), .B(B),
    .Q(Q), .R(R), .done(done), .busy(busy), .dbz(dbz), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Returns number of rising edges until done is seen; bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (done !== 1'b1) chk("done_timeout", {31'd0, done}, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int cyc);
    @(negedge clk);
    A   = a;
    B   = b;
    ena = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    wait_done(cyc);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t vecs[5] = '{
    '{8'd255, 4'd1,  8'd255, 4'd0},
    '{8'd15,  4'd15, 8'd1,   4'd0},
    '{8'd0,   4'd5,  8'd0,   4'd0},
    '{8'd225, 4'd15, 8'd15,  4'd0},
    '{8'd7,   4'd9,  8'd0,   4'd7}
  };

  initial begin
    int cyc;
    logic seen;

    // reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_q", {24'd0, Q}, 0);
    chk("rst_r", {28'd0, R}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_dbz", {31'd0, dbz}, 0);
    rst = 1'b1;

    // basic op and latency
    run_op(8'd200, 4'd7, cyc);
    chk("lat_200_7", cyc, 10);
    chk("q_200_7", {24'd0, Q}, 28);
    chk("r_200_7", {28'd0, R}, 4);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 0);

    // directed pairs
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, cyc);
      chk("dir_q", {24'd0, Q}, {24'd0, vecs[i].q});
      chk("dir_r", {28'd0, R}, {28'd0, vecs[i].r});
    end

    // exhaustive sweep
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(a[7:0], b[3:0], cyc);
        chk("sweep_q", {24'd0, Q}, a / b);
        chk("sweep_r", {28'd0, R}, a % b);
      end
    end

    // divide by zero
    run_op(8'd100, 4'd0, cyc);
    chk("dbz_q", {24'd0, Q}, 255);
`ifdef DIVIDER_DBZ_CHECK_EN
    chk("dbz_r", {28'd0, R}, 0);
    chk("dbz_flag", {31'd0, dbz}, 1);
`else
    chk("dbz_lat", cyc, 10);
    chk("dbz_r", {28'd0, R}, 4);
    chk("dbz_flag", {31'd0, dbz}, 0);
`endif

    // operand change mid-op, then ena held high
    @(negedge clk);
    A   = 8'd200;
    B   = 4'd7;
    ena = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (4) @(negedge clk);
    A   = 8'd9;
    B   = 4'd3;
    ena = 1'b1;
    wait_done(cyc);
    chk("hold_lat", cyc, 6);
    chk("hold_q", {24'd0, Q}, 28);
    chk("hold_r", {28'd0, R}, 4);
    chk("gap_state", {29'd0, state}, 0);
    chk("gap_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("restart_state", {29'd0, state}, 1);
    ena = 1'b0;
    wait_done(cyc);
    chk("second_lat", cyc, 10);
    chk("second_q", {24'd0, Q}, 3);
    chk("second_r", {28'd0, R}, 0);

    // abort by reset
    run_op(8'd47, 4'd5, cyc);
    chk("pre_q", {24'd0, Q}, 9);
    @(negedge clk);
    A   = 8'd200;
    B   = 4'd7;
    ena = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state", {29'd0, state}, 0);
    chk("abort_q", {24'd0, Q}, 0);
    chk("abort_r", {28'd0, R}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 0);
    run_op(8'd200, 4'd7, cyc);
    chk("after_lat", cyc, 10);
    chk("after_q", {24'd0, Q}, 28);
    chk("after_r", {28'd0, R}, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
